// File: rtl/shift_unit_arb.sv
// Shared 32-bit shift unit: two requesters arbitrated round-robin onto one
// left-shift datapath (right shifts via bit reversal), one registered result slot.
module shift_unit_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_id
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Handshake: a port transfers when valid & ready in the same cycle; ready is
  // offered only to the granted port while the result slot is free.

  // Zero-fill logarithmic left shifter, stages of 1/2/4/8/16.
  function automatic logic [WIDTH-1:0] lsh(input logic [WIDTH-1:0] a, input logic [4:0] s);
    logic [WIDTH-1:0] t;
    t = a;
    if (s[0]) t = {t[WIDTH-2:0], 1'b0};
    if (s[1]) t = {t[WIDTH-3:0], 2'b0};
    if (s[2]) t = {t[WIDTH-5:0], 4'b0};
    if (s[3]) t = {t[WIDTH-9:0], 8'b0};
    if (s[4]) t = {t[WIDTH-17:0], 16'b0};
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) t[i] = a[WIDTH-1-i];
    return t;
  endfunction

  logic             last_grant;
  logic             grant1;
  logic             slot_free;
  logic             take;
  logic [WIDTH-1:0] sel_a;
  logic [4:0]       sel_s;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] y_sll, y_srl, y_fill, y_sra, y_next;

  // Requester 1 wins when it is alone, or when both contend and req0 went last.
  assign grant1     = req1_valid & (!req0_valid | !last_grant);
  assign slot_free  = !rsp_valid | rsp_ready;
  assign req0_ready = slot_free & !grant1 & !rst;
  assign req1_ready = slot_free & grant1 & !rst;
  assign take       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel_a  = grant1 ? req1_a     : req0_a;
  assign sel_s  = grant1 ? req1_shamt : req0_shamt;
  assign sel_op = grant1 ? req1_op    : req0_op;

  assign y_sll  = lsh(sel_a, sel_s);
  assign y_srl  = rev(lsh(rev(sel_a), sel_s));
  // Second shifter builds a mask of the upper shamt bits for sign fill.
  assign y_fill = rev(~lsh({WIDTH{1'b1}}, sel_s));
  assign y_sra  = y_srl | (sel_a[WIDTH-1] ? y_fill : '0);

  always_comb begin
    y_next = y_sll;
    case (sel_op)
      OP_SLL:  y_next = y_sll;
      OP_SRL:  y_next = y_srl;
      OP_SRA:  y_next = y_sra;
      default: y_next = y_sll;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (take) begin
      rsp_valid  <= 1'b1;
      rsp_y      <= y_next;
      rsp_id     <= grant1;
      last_grant <= grant1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_unit_arb.sv
// Randomized and directed bench for shift_unit_arb against an arithmetic
// reference model with a one-deep expected-result queue.
module tb_shift_unit_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a;
  logic [4:0]  req0_shamt;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a;
  logic [4:0]  req1_shamt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_id;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  shift_unit_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];  // {id, y}
  bit          mdl_last;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic [1:0] op);
    case (op)
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a << s;
    endcase
  endfunction

  // One clock: check readys before the edge, update model at the edge,
  // check the result slot at the following negedge.
  task automatic cycle();
    bit          free, g, push;
    logic [31:0] y;
    #1;
    free = (exp_q.size() == 0) || rsp_ready;
    g    = (req0_valid && req1_valid) ? !mdl_last : req1_valid;
    if (rst || !free) begin
      check("ready0_blocked", 32'(req0_ready), 32'd0);
      check("ready1_blocked", 32'(req1_ready), 32'd0);
    end else begin
      if (req0_valid) check("ready0_grant", 32'(req0_ready), 32'(!g));
      if (req1_valid) check("ready1_grant", 32'(req1_ready), 32'(g));
    end
    @(posedge clk);
    push = 1'b0;
    y    = '0;
    if (rst) begin
      exp_q.delete();
      mdl_last = 1'b1;
    end else begin
      if (free && (req0_valid || req1_valid)) begin
        push = 1'b1;
        y = g ? ref_shift(req1_a, req1_shamt, req1_op) : ref_shift(req0_a, req0_shamt, req0_op);
      end
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({g, y});
        mdl_last = g;
      end
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_y", rsp_y, exp_q[0][31:0]);
      check("rsp_id", 32'(rsp_id), 32'(exp_q[0][32]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set0(input logic v, input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    req0_valid = v; req0_a = a; req0_shamt = s; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    req1_valid = v; req1_a = a; req1_shamt = s; req1_op = op;
  endtask

  task automatic rnd_req();
    set0(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    set1(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mdl_last  = 1'b1;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    cycle();
    cycle();
    check("rst_y", rsp_y, 32'h0);
    check("rst_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;

    // first request after reset
    set0(1'b1, 32'h0000_0001, 5'd31, 2'b00);
    cycle();
    check("sll31_y", rsp_y, 32'h8000_0000);
    set0(1'b0, '0, '0, '0);

    // requester 1 alone
    set1(1'b1, 32'h8000_0000, 5'd4, 2'b10);
    cycle();
    check("sra4_y", rsp_y, 32'hF800_0000);
    check("sra4_id", 32'(rsp_id), 32'd1);
    set1(1'b1, 32'h8000_0000, 5'd4, 2'b01);
    cycle();
    check("srl4_y", rsp_y, 32'h0800_0000);
    set1(1'b1, 32'h7FFF_FFFF, 5'd31, 2'b10);
    cycle();
    check("sra31_pos_y", rsp_y, 32'h0000_0000);
    set1(1'b1, 32'h8000_0001, 5'd31, 2'b10);
    cycle();
    check("sra31_neg_y", rsp_y, 32'hFFFF_FFFF);
    set1(1'b0, '0, '0, '0);

    // shamt = 0 for every opcode, and opcode 11 behaving as SLL
    for (int op = 0; op < 4; op++) begin
      set0(1'b1, 32'hA5A5_A5A5, 5'd0, 2'(op));
      cycle();
      check("shamt0_y", rsp_y, 32'hA5A5_A5A5);
    end
    set0(1'b1, 32'h0000_00FF, 5'd8, 2'b11);
    cycle();
    check("op11_y", rsp_y, 32'h0000_FF00);
    set0(1'b0, '0, '0, '0);
    cycle();

    // contention from a fresh reset: alternating grants
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rnd_req();
      cycle();
      check("rr_id", 32'(rsp_id), 32'(i % 2));
      check("rr_valid", 32'(rsp_valid), 32'd1);
    end

    // backpressure with a pending 0x1234_0000
    set0(1'b1, 32'h0000_1234, 5'd16, 2'b00);
    set1(1'b0, '0, '0, '0);
    cycle();
    rnd_req();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_y", rsp_y, 32'h1234_0000);
      check("bp_id", 32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_release_id", 32'(rsp_id), 32'd1);
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    cycle();

    // reset while a result is pending and both requesters are valid
    set0(1'b1, 32'h0000_0003, 5'd1, 2'b00);
    cycle();
    rnd_req();
    rsp_ready = 1'b0;
    rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    check("post_rst_id", 32'(rsp_id), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      set0(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      set1(($urandom_range(0, 2) != 0), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shift_unit_arb.md
# shift_unit_arb

Shared shift execution unit that arbitrates one left-shift datapath between two requesters (e.g. ALU port and load/store alignment port). Performs SLL, SRL and SRA on 32-bit operands, with right shifts implemented by bit-reversal around the left shifter. Has a round-robin grant, valid/ready handshakes on both sides and a single registered result slot, giving 1-cycle latency at full throughput.

## Interface
- WIDTH, 32, operand width; only 32 is supported, since shamt is 5 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand for requester 0.
- req0_shamt  in  5  shift amount for requester 0.
- req0_op  in  2  shift opcode for requester 0: 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- req1_valid / req1_ready / req1_a / req1_shamt / req1_op  same as requester 0, for requester 1.
- rsp_valid  out  1  result slot holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_y  out  WIDTH  shifted result.
- rsp_id  out  1  requester that issued the result (0 or 1).

## Operation
- Transfer on a request port: reqN_valid & reqN_ready. Transfer on the response port: rsp_valid & rsp_ready.
- slot_free = !rsp_valid | rsp_ready.
  - reqN_ready = slot_free & grant_N & !rst.
  - At most one reqN_ready is high per cycle.
  - reqN_ready must not depend on reqN_valid of the same port, except through grant selection.
- Arbitration:
  - Register last_grant is 1 bit; reset value 1, so req0 wins first.
  - If only one requester is valid, it is granted.
  - If both are valid, grant !last_grant.
  - last_grant updates only on a request transfer.
- Datapath, combinational on the granted request:
  - SLL: y = a << shamt.
  - SRL: y = rev(rev(a) << shamt).
  - SRA: y = SRL result | (a[31] ? ~rev(32'hFFFF_FFFF << ... reversed mask) : 0). Equivalently, vacated upper shamt bits are filled with a[31].
  - The left-shift stages are zero-fill, log-structured, 5 stages (1/2/4/8/16).
  - A second shifter instance is permitted for the SRA fill mask.
- On a request transfer: rsp_y <= result, rsp_id <= granted index, rsp_valid <= 1.
- On a response transfer with no request transfer: rsp_valid <= 0.
- Simultaneous response and request transfer in the same cycle: the slot is refilled and rsp_valid stays 1.
- Backpressure (rsp_valid & !rsp_ready): rsp_y and rsp_id are held stable, both readys are 0, and no state changes.
- Fairness: under continuous contention, each requester waits at most one grant.

## Timing
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, last_grant=1. req0_ready=req1_ready=0 while rst=1.
- Reset mid-operation: a pending result is dropped; rsp_valid=0 the cycle after rst.
- Latency: a request accepted at edge k appears on rsp_y/rsp_valid after edge k; the consumer sees it in cycle k+1.
- Throughput: 1 op/cycle when rsp_ready is held high.
- rsp_* outputs are driven directly from flops; there is no combinational path from req inputs to rsp outputs.
- Combinational path rsp_ready -> reqN_ready is allowed, and is the only input->output path besides the valid-driven grant.
- shamt=0 returns a unchanged for every op. shamt=31 with SRA returns a replicated a[31].

## Test plan
- Reset, then req0 SLL a=0x0000_0001, shamt=31, rsp_ready=1 -> req0_ready=1 in the first cycle; next cycle rsp_valid=1, rsp_y=0x8000_0000, rsp_id=0.
- req1 alone, a=0x8000_0000, shamt=4: SRA -> 0xF800_0000, rsp_id=1; SRL -> 0x0800_0000. Also a=0x7FFF_FFFF, SRA shamt=31 -> 0x0000_0000.
- Both valid every cycle, rsp_ready=1, for 6 cycles -> grants and rsp_id sequence 0,1,0,1,0,1 with rsp_valid continuously 1.
- Backpressure: result 0x1234_0000 pending, rsp_ready=0 for 3 cycles -> rsp_y/rsp_id stable and both readys 0. On the cycle rsp_ready=1, a new grant is issued and the next result appears the cycle after.
- Boundary ops: shamt=0 for op 00/01/10/11 with a=0xA5A5_A5A5 -> 0xA5A5_A5A5 each. op=11, shamt=8, a=0x0000_00FF -> 0x0000_FF00.
- Assert rst while rsp_valid=1 and both requesters valid -> next cycle rsp_valid=0 and no readys. After release, the first grant goes to req0.
